// File: rtl/reg_read_stage.sv
// reg_read_stage: 32x32 register file with write-through read bypass,
// load-use hazard detection and the ID/EX operand pipeline latch.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   WEN, wsel, wdat     register write port driven by write-back
//   rs, rt              decode source register indices
//   use_rs, use_rt      decode instruction actually reads rs / rt
//   id_valid            decode slot holds a real instruction
//   idexen, idexflush   ID/EX advance enable and squash
//   ex_memRead, ex_rd   EX-stage instruction is a load, and its destination
//   stall               load-use hazard (combinational)
//   rdat1, rdat2        bypassed decode-time read data (combinational)
//   ex_rdat1, ex_rdat2  latched operands for EX
//   ex_rs, ex_rt        latched source indices for forwarding
//   ex_valid            latched slot validity

module reg_read_stage #(
   parameter int NREGS = 32,
   parameter int DW    = 32,
   parameter int AW    = 5
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          WEN,
   input  logic [AW-1:0] wsel,
   input  logic [DW-1:0] wdat,
   input  logic [AW-1:0] rs,
   input  logic [AW-1:0] rt,
   input  logic          use_rs,
   input  logic          use_rt,
   input  logic          id_valid,
   input  logic          idexen,
   input  logic          idexflush,
   input  logic          ex_memRead,
   input  logic [AW-1:0] ex_rd,
   output logic          stall,
   output logic [DW-1:0] rdat1,
   output logic [DW-1:0] rdat2,
   output logic [DW-1:0] ex_rdat1,
   output logic [DW-1:0] ex_rdat2,
   output logic [AW-1:0] ex_rs,
   output logic [AW-1:0] ex_rt,
   output logic          ex_valid
);

   // ------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------
   logic [DW-1:0] rf_q [NREGS];
   logic [DW-1:0] rf_d [NREGS];

   logic          wr_hit;

   // Index 0 is never written so it always reads back as zero.
   assign wr_hit = WEN && (wsel != '0);

   always_comb begin
      rf_d = rf_q;
      if (wr_hit) begin
         rf_d[wsel] = wdat;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         rf_q <= rf_d;
      end
   end

   // ------------------------------------------------------------
   // Read ports with write-through bypass
   // ------------------------------------------------------------
   // The bypass lets an instruction in decode see a value that
   // write-back is committing on this very edge.
   always_comb begin
      rdat1 = '0;
      if (rs == '0) begin
         rdat1 = '0;
      end else if (WEN && (wsel == rs)) begin
         rdat1 = wdat;
      end else begin
         rdat1 = rf_q[rs];
      end
   end

   always_comb begin
      rdat2 = '0;
      if (rt == '0) begin
         rdat2 = '0;
      end else if (WEN && (wsel == rt)) begin
         rdat2 = wdat;
      end else begin
         rdat2 = rf_q[rt];
      end
   end

   // ------------------------------------------------------------
   // Load-use hazard
   // ------------------------------------------------------------
   logic rs_hit;
   logic rt_hit;
   logic ex_load;

   assign ex_load = ex_memRead && ex_valid && (ex_rd != '0);
   assign rs_hit  = use_rs && (rs == ex_rd);
   assign rt_hit  = use_rt && (rt == ex_rd);
   assign stall   = id_valid && ex_load && (rs_hit || rt_hit);

   // ------------------------------------------------------------
   // ID/EX latch
   // ------------------------------------------------------------
   logic [DW-1:0] ex_rdat1_q, ex_rdat1_d;
   logic [DW-1:0] ex_rdat2_q, ex_rdat2_d;
   logic [AW-1:0] ex_rs_q,    ex_rs_d;
   logic [AW-1:0] ex_rt_q,    ex_rt_d;
   logic          ex_valid_q, ex_valid_d;
   logic          bubble;

   // A flush always squashes; a stall only squashes when the latch
   // would otherwise advance, so a frozen pipe keeps its contents.
   assign bubble = idexflush || (idexen && stall);

   always_comb begin
      ex_rdat1_d = ex_rdat1_q;
      ex_rdat2_d = ex_rdat2_q;
      ex_rs_d    = ex_rs_q;
      ex_rt_d    = ex_rt_q;
      ex_valid_d = ex_valid_q;
      if (bubble) begin
         ex_rdat1_d = '0;
         ex_rdat2_d = '0;
         ex_rs_d    = '0;
         ex_rt_d    = '0;
         ex_valid_d = 1'b0;
      end else if (idexen) begin
         ex_rdat1_d = rdat1;
         ex_rdat2_d = rdat2;
         ex_rs_d    = rs;
         ex_rt_d    = rt;
         ex_valid_d = id_valid;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ex_rdat1_q <= '0;
         ex_rdat2_q <= '0;
         ex_rs_q    <= '0;
         ex_rt_q    <= '0;
         ex_valid_q <= 1'b0;
      end else begin
         ex_rdat1_q <= ex_rdat1_d;
         ex_rdat2_q <= ex_rdat2_d;
         ex_rs_q    <= ex_rs_d;
         ex_rt_q    <= ex_rt_d;
         ex_valid_q <= ex_valid_d;
      end
   end

   assign ex_rdat1 = ex_rdat1_q;
   assign ex_rdat2 = ex_rdat2_q;
   assign ex_rs    = ex_rs_q;
   assign ex_rt    = ex_rt_q;
   assign ex_valid = ex_valid_q;

endmodule
